// File: rtl/regfile_pkg.sv
// Shared types and constants for the RISC-V integer register file.
// Index width is fixed at five bits to match the rd/rs1/rs2 instruction fields.
package regfile_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;

    typedef logic [4:0]          reg_idx_t;
    typedef logic [XLEN_DEF-1:0] xlen_t;

    localparam reg_idx_t REG_ZERO = 5'd0;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: x0 and out-of-range indexes read zero.
// With REGFILE_BYPASS_EN defined, a same-cycle write to the read index is forwarded.
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = NREGS_DEF
) (
    input  logic [4:0]      rdAddr,
    input  logic [XLEN-1:0] regs [1:NREGS-1],
    input  logic            we,
    input  logic [4:0]      wrAddr,
    input  logic [XLEN-1:0] wrData,
    output logic [XLEN-1:0] rdData
);

`ifndef REGFILE_BYPASS_EN
    logic unusedWriteSide;
    assign unusedWriteSide = ^{we, wrAddr, wrData};
`endif

    // The loop starts at 1, so x0 and any index with no storage fall through to zero.
    always_comb begin
        rdData = '0;
        for (int i = 1; i < NREGS; i++) begin
            if (rdAddr == reg_idx_t'(i)) begin
                rdData = regs[i];
`ifdef REGFILE_BYPASS_EN
                if (we && (wrAddr == rdAddr)) begin
                    rdData = wrData;
                end
`endif
            end
        end
    end

endmodule

// File: rtl/register_file.sv
// RISC-V integer register file: 32 x XLEN, two combinational reads, one synchronous write.
// Optional write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module register_file
    import regfile_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = NREGS_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            we,
    input  logic [4:0]      wrAddr,
    input  logic [4:0]      rdAddr1,
    input  logic [4:0]      rdAddr2,
    input  logic [XLEN-1:0] wrData,
    output logic [XLEN-1:0] rdData1,
    output logic [XLEN-1:0] rdData2
);

    // x0 has no storage; index 0 never matches a slot below.
    logic [XLEN-1:0] regs [1:NREGS-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 1; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (wrAddr != REG_ZERO)) begin
            for (int i = 1; i < NREGS; i++) begin
                if (wrAddr == reg_idx_t'(i)) begin
                    regs[i] <= wrData;
                end
            end
        end
    end

    regfile_read_port #(
        .XLEN  (XLEN),
        .NREGS (NREGS)
    ) readPort1 (
        .rdAddr (rdAddr1),
        .regs   (regs),
        .we     (we),
        .wrAddr (wrAddr),
        .wrData (wrData),
        .rdData (rdData1)
    );

    regfile_read_port #(
        .XLEN  (XLEN),
        .NREGS (NREGS)
    ) readPort2 (
        .rdAddr (rdAddr2),
        .regs   (regs),
        .we     (we),
        .wrAddr (wrAddr),
        .wrData (wrData),
        .rdData (rdData2)
    );

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: stimulus pushes expected read data into a
// scoreboard queue, and a monitor pops and compares on every sample strobe.
module tb_register_file;

    logic        clk;
    logic        rst;
    logic        we;
    logic [4:0]  wrAddr;
    logic [4:0]  rdAddr1;
    logic [4:0]  rdAddr2;
    logic [31:0] wrData;
    logic [31:0] rdData1;
    logic [31:0] rdData2;

    logic [31:0] expQ1[$];
    logic [31:0] expQ2[$];
    string       nameQ[$];
    logic        sampleStb;
    int          checksTotal;
    int          checksPassed;

    register_file dut (
        .clk     (clk),
        .rst     (rst),
        .we      (we),
        .wrAddr  (wrAddr),
        .rdAddr1 (rdAddr1),
        .rdAddr2 (rdAddr2),
        .wrData  (wrData),
        .rdData1 (rdData1),
        .rdData2 (rdData2)
    );

    // Clock: 10 ns period, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    // Monitor: each strobe presents one sample on both read ports.
    initial begin
        logic [31:0] e1;
        logic [31:0] e2;
        string       nm;
        forever begin
            @(sampleStb);
            if (expQ1.size() == 0) begin
                checksTotal++;
                $display("FAIL scoreboard: sample with empty expected queue, actual rdData1=%08h rdData2=%08h",
                         rdData1, rdData2);
            end else begin
                e1 = expQ1.pop_front();
                e2 = expQ2.pop_front();
                nm = nameQ.pop_front();
                checksTotal++;
                if (rdData1 === e1) checksPassed++;
                else $display("FAIL %s port1: actual=%08h required=%08h", nm, rdData1, e1);
                checksTotal++;
                if (rdData2 === e2) checksPassed++;
                else $display("FAIL %s port2: actual=%08h required=%08h", nm, rdData2, e2);
            end
        end
    end

    // Drive read addresses, let combinational paths settle, then hand the sample to the monitor.
    task automatic checkRead(input string nm, input logic [4:0] a1, input logic [4:0] a2,
                             input logic [31:0] e1, input logic [31:0] e2);
        rdAddr1 = a1;
        rdAddr2 = a2;
        #1;
        expQ1.push_back(e1);
        expQ2.push_back(e2);
        nameQ.push_back(nm);
        sampleStb = ~sampleStb;
        #1;
    endtask

    task automatic writeReg(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        we     = 1'b1;
        wrAddr = a;
        wrData = d;
        @(negedge clk);
        we     = 1'b0;
    endtask

    initial begin
        checksTotal  = 0;
        checksPassed = 0;
        sampleStb    = 1'b0;
        rst     = 1'b1;
        we      = 1'b0;
        wrAddr  = 5'd0;
        wrData  = 32'h0;
        rdAddr1 = 5'd0;
        rdAddr2 = 5'd0;

        // Reset held for 10 ns; outputs read zero during and after it.
        #2;
        checkRead("in_reset", 5'd1, 5'd31, 32'h0, 32'h0);
        #6;
        rst = 1'b0;
        checkRead("after_reset_a", 5'd1, 5'd31, 32'h0, 32'h0);
        checkRead("after_reset_b", 5'd31, 5'd1, 32'h0, 32'h0);

        // Basic write then read.
        writeReg(5'd1, 32'hDEADBEEF);
        checkRead("write_x1", 5'd1, 5'd0, 32'hDEADBEEF, 32'h0);

        // Writes to x0 are dropped.
        writeReg(5'd0, 32'hFFFFFFFF);
        checkRead("x0_write", 5'd0, 5'd0, 32'h0, 32'h0);

        // we=0 leaves x1 untouched even with a live address and data.
        @(negedge clk);
        we     = 1'b0;
        wrAddr = 5'd1;
        wrData = 32'h12345678;
        @(negedge clk);
        checkRead("we0_hold", 5'd1, 5'd1, 32'hDEADBEEF, 32'hDEADBEEF);

        // Independent ports and the top boundary register.
        writeReg(5'd5, 32'hA5A5A5A5);
        writeReg(5'd6, 32'h5A5A5A5A);
        checkRead("dual_port", 5'd5, 5'd6, 32'hA5A5A5A5, 32'h5A5A5A5A);
        checkRead("dual_swap", 5'd6, 5'd5, 32'h5A5A5A5A, 32'hA5A5A5A5);
        writeReg(5'd31, 32'h80000001);
        checkRead("x31_same_addr", 5'd31, 5'd31, 32'h80000001, 32'h80000001);
        checkRead("x0_with_data", 5'd0, 5'd1, 32'h0, 32'hDEADBEEF);

        // Same-cycle read and write of x7 (x7 is still zero before the edge).
        @(negedge clk);
        we     = 1'b1;
        wrAddr = 5'd7;
        wrData = 32'hCAFEF00D;
`ifdef REGFILE_BYPASS_EN
        checkRead("collide_before", 5'd7, 5'd0, 32'hCAFEF00D, 32'h0);
`else
        checkRead("collide_before", 5'd7, 5'd0, 32'h0, 32'h0);
`endif
        @(posedge clk);
        #1;
        checkRead("collide_after", 5'd7, 5'd7, 32'hCAFEF00D, 32'hCAFEF00D);
        @(negedge clk);
        we = 1'b0;
        checkRead("collide_held", 5'd7, 5'd1, 32'hCAFEF00D, 32'hDEADBEEF);

        // Asynchronous reset between edges clears storage without a clock.
        @(negedge clk);
        checkRead("pre_async_rst", 5'd5, 5'd6, 32'hA5A5A5A5, 32'h5A5A5A5A);
        rst = 1'b1;
        checkRead("async_rst", 5'd5, 5'd6, 32'h0, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        checkRead("after_async_rst", 5'd1, 5'd31, 32'h0, 32'h0);

        // Reset asserted across a write edge: reset wins.
        @(negedge clk);
        we     = 1'b1;
        wrAddr = 5'd9;
        wrData = 32'h11111111;
        rst    = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        we  = 1'b0;
        rst = 1'b0;
        checkRead("rst_mid_write", 5'd9, 5'd9, 32'h0, 32'h0);

        // Register file works normally again after reset.
        writeReg(5'd9, 32'h0F0F0F0F);
        checkRead("post_rst_write", 5'd9, 5'd5, 32'h0F0F0F0F, 32'h0);

        #5;
        checksTotal++;
        if (expQ1.size() == 0) checksPassed++;
        else $display("FAIL scoreboard_drain: actual=%0d pending required=0 pending", expQ1.size());

        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule
